// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the lock-state encoding for the VGA timing recovery block.
package vga_pkg;

    localparam int VGA_CNT_W    = 10;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        LOCK_SEARCH = 2'd0,
        LOCK_VERIFY = 2'd1,
        LOCK_LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vga_timing_recovery_if.sv
// Sync inputs and recovered timing outputs of vga_timing_recovery.
interface vga_timing_recovery_if;
    import vga_pkg::*;

    logic                 hsync;
    logic                 vsync;
    logic [VGA_CNT_W-1:0] x;
    logic [VGA_CNT_W-1:0] y;
    logic                 active;
    logic [VGA_CNT_W-1:0] h_total;
    logic [VGA_CNT_W-1:0] v_total;
    logic                 locked;
    logic                 sync_error;

    modport master (
        output hsync, vsync,
        input  x, y, active, h_total, v_total, locked, sync_error
    );

    modport slave (
        input  hsync, vsync,
        output x, y, active, h_total, v_total, locked, sync_error
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Registers one sync input and flags its leading (to SYNC_POL) and trailing (away from SYNC_POL) edges.
module sync_edge_detect #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic lead,
    output logic trail
);
    logic sync_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_p0 <= ~SYNC_POL;
        else       sync_p0 <= sync_in;
    end

    // Edges compare the live input with last cycle's sample, so they act on the current sample.
    assign lead  = (sync_in == SYNC_POL) && (sync_p0 != SYNC_POL);
    assign trail = (sync_in != SYNC_POL) && (sync_p0 == SYNC_POL);
endmodule

// File: rtl/vga_timing_recovery.sv
// Recovers pixel/line position, measured periods and lock status from a free-running hsync/vsync pair.
module vga_timing_recovery
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_timing_recovery_if.slave vif
);
    localparam logic [1:0]  SEARCH = LOCK_SEARCH;
    localparam logic [1:0]  VERIFY = LOCK_VERIFY;
    localparam logic [1:0]  LOCKED = LOCK_LOCKED;

    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [9:0]  H_TOT   = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [10:0] H_LO    = 11'(H_BACK);
    localparam logic [10:0] H_HI    = 11'(H_BACK + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_BACK);
    localparam logic [10:0] V_HI    = 11'(V_BACK + V_ACTIVE);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    logic       h_lead, h_trail, v_lead, v_trail;
    logic [9:0] h_cnt, h_per, v_cnt, v_per;
    logic [9:0] h_total_r, v_total_r;
    logic       v_pend;
    logic [1:0] state;
    logic [7:0] match_cnt;
    logic       frame_ok;
    logic       sync_err_r;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hsync (
        .clk(clk), .reset(reset), .sync_in(vif.hsync), .lead(h_lead), .trail(h_trail)
    );
    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vsync (
        .clk(clk), .reset(reset), .sync_in(vif.vsync), .lead(v_lead), .trail(v_trail)
    );

    logic [9:0] h_per_nxt;
    logic [9:0] v_lines;
    logic       line_bad;

    assign h_per_nxt = h_lead ? '0 : sat_inc(h_per);
    // A line whose hsync leading edge coincides with vsync still belongs to the frame being closed.
    assign v_lines   = h_lead ? sat_inc(v_per) : v_per;
    assign line_bad  = h_lead && (sat_inc(h_per) != H_TOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            h_per     <= '0;
            v_cnt     <= '0;
            v_per     <= '0;
            v_pend    <= 1'b0;
            h_total_r <= '0;
            v_total_r <= '0;
        end else begin
            h_cnt  <= h_trail ? '0 : sat_inc(h_cnt);
            h_per  <= h_per_nxt;
            if (h_lead) h_total_r <= sat_inc(h_per);
            if (h_trail) v_cnt <= v_pend ? '0 : sat_inc(v_cnt);
            v_pend <= v_trail | (v_pend & ~h_trail);
            v_per  <= v_lead ? '0 : v_lines;
            if (v_lead) v_total_r <= v_lines;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            frame_ok   <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_lead) begin
                        state     <= VERIFY;
                        match_cnt <= '0;
                        frame_ok  <= 1'b1;
                    end
                end
                VERIFY: begin
                    if (v_lead) begin
                        frame_ok <= 1'b1;
                        if (frame_ok && !line_bad && (v_lines == V_TOT)) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt + 8'd1 == LOCK_N) state <= LOCKED;
                        end else begin
                            state <= SEARCH;
                        end
                    end else if (line_bad) begin
                        frame_ok <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (line_bad || (v_lead && (v_lines != V_TOT)) || (h_per_nxt == CNT_MAX)) begin
                        state      <= SEARCH;
                        sync_err_r <= 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    logic is_locked, h_win, v_win, act;

    assign is_locked = (state == LOCKED);
    assign h_win     = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
    assign v_win     = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);
    assign act       = is_locked && h_win && v_win;

    assign vif.active     = act;
    assign vif.x          = act ? (h_cnt - H_LO[9:0]) : '0;
    assign vif.y          = act ? (v_cnt - V_LO[9:0]) : '0;
    assign vif.h_total    = h_total_r;
    assign vif.v_total    = v_total_r;
    assign vif.locked     = is_locked;
    assign vif.sync_error = sync_err_r;
endmodule

// File: tb/tb_vga_timing_recovery.sv
// Scoreboard bench: randomized sync streams on active-low and active-high instances against an event-time model.
`timescale 1ns/1ps
module tb_vga_timing_recovery;
    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HB  = 4;
    localparam int HA  = 24;
    localparam int VB  = 3;
    localparam int VA  = 12;
    localparam int LF  = 2;
    localparam int VSW = 2;

    logic clk = 1'b1;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_timing_recovery_if bus0();
    vga_timing_recovery_if bus1();

    vga_timing_recovery #(.H_TOTAL(HT), .V_TOTAL(VT), .H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB),
        .V_ACTIVE(VA), .SYNC_POL(1'b0), .LOCK_FRAMES(LF))
        dut0 (.clk(clk), .reset(reset), .vif(bus0.slave));

    vga_timing_recovery #(.H_TOTAL(HT), .V_TOTAL(VT), .H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB),
        .V_ACTIVE(VA), .SYNC_POL(1'b1), .LOCK_FRAMES(LF))
        dut1 (.clk(clk), .reset(reset), .vif(bus1.slave));

    typedef struct {
        logic [9:0] x, y, h_total, v_total;
        logic       active, locked, sync_error;
        bit         vlead;
        bit         rst;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: positions and periods are distances between recorded sync event times.
    int m_t, m_last_hlead, m_last_htrail, m_htrails, m_vanchor, m_hleads, m_hleads_vl;
    int m_htotal, m_vtotal, m_phase, m_good;
    bit m_prev_hs, m_prev_vs, m_vpend, m_clean;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_last_hlead = 0; m_last_htrail = 0; m_htrails = 0; m_vanchor = 0;
        m_hleads = 0; m_hleads_vl = 0; m_htotal = 0; m_vtotal = 0; m_phase = 0; m_good = 0;
        m_prev_hs = 0; m_prev_vs = 0; m_vpend = 0; m_clean = 0;
    endtask

    task automatic model_step(input bit hs, input bit vs, output exp_t e);
        bit hl, ht, vl, vt, bad, err, lck, act;
        int period, lines, hc, vc, hp;
        m_t++;
        hl = hs && !m_prev_hs;  ht = !hs && m_prev_hs;
        vl = vs && !m_prev_vs;  vt = !vs && m_prev_vs;
        m_prev_hs = hs; m_prev_vs = vs;
        bad = 0; err = 0; lines = 0;
        if (hl) begin
            period = m_t - m_last_hlead;
            m_htotal = sat(period);
            bad = (period != HT);
            m_last_hlead = m_t;
            m_hleads++;
        end
        if (ht) begin
            m_htrails++;
            if (m_vpend) begin m_vanchor = m_htrails; m_vpend = 0; end
            m_last_htrail = m_t;
        end
        if (vt) m_vpend = 1;
        if (vl) begin
            lines = m_hleads - m_hleads_vl;
            m_vtotal = sat(lines);
            m_hleads_vl = m_hleads;
        end
        hp = sat(m_t - m_last_hlead);
        case (m_phase)
            0: if (vl) begin m_phase = 1; m_good = 0; m_clean = 1; end
            1: begin
                if (bad) m_clean = 0;
                if (vl) begin
                    if (m_clean && lines == VT) begin
                        m_good++;
                        if (m_good == LF) m_phase = 2;
                    end else m_phase = 0;
                    m_clean = 1;
                end
            end
            default: if (bad || (vl && lines != VT) || hp == 1023) begin m_phase = 0; err = 1; end
        endcase
        hc  = sat(m_t - m_last_htrail);
        vc  = sat(m_htrails - m_vanchor);
        lck = (m_phase == 2);
        act = lck && hc >= HB && hc < HB + HA && vc >= VB && vc < VB + VA;
        e.x = act ? 10'(hc - HB) : 10'd0;
        e.y = act ? 10'(vc - VB) : 10'd0;
        e.h_total = 10'(m_htotal);
        e.v_total = 10'(m_vtotal);
        e.active = act; e.locked = lck; e.sync_error = err;
        e.vlead = vl; e.rst = 0;
    endtask

    task automatic drive_cycle(input bit hs, input bit vs);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        bus0.hsync = ~hs; bus0.vsync = ~vs;
        bus1.hsync = hs;  bus1.vsync = vs;
        model_step(hs, vs, e);
        expq.push_back(e);
    endtask

    task automatic reset_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            bus0.hsync = 1'b1; bus0.vsync = 1'b1;
            bus1.hsync = 1'b0; bus1.vsync = 1'b0;
            model_reset();
            e.x = '0; e.y = '0; e.h_total = '0; e.v_total = '0;
            e.active = 0; e.locked = 0; e.sync_error = 0; e.vlead = 0; e.rst = 1;
            expq.push_back(e);
        end
    endtask

    // cut >= 0 stops the frame after that many cycles.
    task automatic drive_frame(input int nlines, input int long_line, input int long_len, input int cut);
        int n;
        n = 0;
        for (int l = 0; l < nlines; l++) begin
            int len, hsw;
            len = (l == long_line) ? long_len : HT;
            hsw = $urandom_range(2, 8);
            for (int c = 0; c < len; c++) begin
                if (cut >= 0 && n == cut) return;
                drive_cycle(c < hsw, l < VSW);
                n++;
            end
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic check_out(input string nm, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] ht, input logic [9:0] vt, input logic act,
                             input logic lck, input logic serr, input exp_t e);
        checks++;
        if ({x, y, ht, vt, act, lck, serr} !== {e.x, e.y, e.h_total, e.v_total, e.active, e.locked, e.sync_error}) begin
            errors++;
            $display("FAIL %s t=%0t got x=%0d y=%0d act=%0b lck=%0b serr=%0b htot=%0d vtot=%0d required x=%0d y=%0d act=%0b lck=%0b serr=%0b htot=%0d vtot=%0d",
                     nm, $time, x, y, act, lck, serr, ht, vt,
                     e.x, e.y, e.active, e.locked, e.sync_error, e.h_total, e.v_total);
        end
    endtask

    // Monitor: pops one expectation per clock and also checks per-frame properties against constants.
    initial begin
        exp_t e;
        bit   fr_valid, fr_locked, fr_first, prev_locked;
        int   fr_act;
        logic [9:0] last_x, last_y;
        fr_valid = 0; fr_locked = 0; fr_first = 0; prev_locked = 0; fr_act = 0;
        last_x = '0; last_y = '0;
        forever begin
            @(posedge clk); #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check_out("cycle_pol0", bus0.x, bus0.y, bus0.h_total, bus0.v_total, bus0.active, bus0.locked, bus0.sync_error, e);
                check_out("cycle_pol1", bus1.x, bus1.y, bus1.h_total, bus1.v_total, bus1.active, bus1.locked, bus1.sync_error, e);
                if (bus0.locked && !prev_locked) begin
                    checks++;
                    if (!e.vlead || bus0.h_total != 10'(HT) || bus0.v_total != 10'(VT)) begin
                        errors++;
                        $display("FAIL lock_rise t=%0t got vlead=%0b htot=%0d vtot=%0d required vlead=1 htot=%0d vtot=%0d",
                                 $time, e.vlead, bus0.h_total, bus0.v_total, HT, VT);
                    end
                end
                prev_locked = bus0.locked;
                if (e.rst) begin
                    fr_valid = 0;
                end else begin
                    if (e.vlead) begin
                        if (fr_valid && fr_locked) begin
                            checks++;
                            if (fr_act != HA * VA) begin
                                errors++;
                                $display("FAIL active_count t=%0t got %0d required %0d", $time, fr_act, HA * VA);
                            end
                            checks++;
                            if (last_x != 10'(HA - 1) || last_y != 10'(VA - 1)) begin
                                errors++;
                                $display("FAIL last_pixel t=%0t got x=%0d y=%0d required x=%0d y=%0d",
                                         $time, last_x, last_y, HA - 1, VA - 1);
                            end
                        end
                        fr_valid = 1; fr_locked = 1; fr_first = 1; fr_act = 0;
                    end
                    if (fr_valid) begin
                        fr_locked = fr_locked && bus0.locked;
                        if (bus0.active) begin
                            fr_act++;
                            if (fr_first) begin
                                checks++;
                                if (bus0.x != 10'd0 || bus0.y != 10'd0) begin
                                    errors++;
                                    $display("FAIL first_pixel t=%0t got x=%0d y=%0d required x=0 y=0", $time, bus0.x, bus0.y);
                                end
                                fr_first = 0;
                            end
                            last_x = bus0.x; last_y = bus0.y;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        bus0.hsync = 1'b1; bus0.vsync = 1'b1;
        bus1.hsync = 1'b0; bus1.vsync = 1'b0;
        model_reset();
        reset_cycles(3);
        repeat (5) drive_frame(VT, -1, 0, -1);
        drive_frame(VT, 7, HT + 1, -1);
        drive_frame(VT - 1, -1, 0, -1);
        repeat (4) drive_frame(VT, -1, 0, -1);
        drive_idle(1100);
        repeat (4) drive_frame(VT, -1, 0, -1);
        drive_frame(VT, -1, 0, $urandom_range(100, 700));
        reset_cycles(3);
        repeat (4) drive_frame(VT, -1, 0, -1);
        for (int i = 0; i < 14; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 5)
                drive_frame(VT, -1, 0, -1);
            else if (k == 6)
                drive_frame(VT, $urandom_range(0, VT - 1),
                            ($urandom_range(0, 1) == 1) ? HT + $urandom_range(1, 3) : HT - $urandom_range(1, 3), -1);
            else if (k == 7)
                drive_frame(($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1, -1, 0, -1);
            else if (k == 8) begin
                drive_frame(VT, -1, 0, $urandom_range(50, 700));
                drive_idle($urandom_range(200, 1100));
            end else begin
                drive_frame(VT, -1, 0, $urandom_range(10, 790));
                reset_cycles($urandom_range(1, 3));
            end
        end
        repeat (4) drive_frame(VT, -1, 0, -1);
        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
